uart_bus_arbiter: RTL
=====================

UART_BUS_ARBITER -- requirements
Module: uart_bus_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16, meaning address width of all ports.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning data width of all ports.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic SHALL be on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-005 The block SHALL have ports sN_write / sN_read, input, 1, requester N (N=1..3) command strobes.
REQ-006 The block SHALL have ports sN_address, input, ADDR_W, and sN_writedata, input, DATA_W, carrying requester N's command fields.
REQ-007 The block SHALL have port sN_waitrequest, output, 1, stall to requester N.
REQ-008 The block SHALL have ports sN_readdatavalid, output, 1, and sN_readdata, output, DATA_W, carrying the read return to requester N.
REQ-009 The block SHALL have ports m_write / m_read, output, 1, the shared downstream master strobes.
REQ-010 The block SHALL have ports m_address, output, ADDR_W, and m_writedata, output, DATA_W, carrying the downstream command fields.
REQ-011 The block SHALL have ports m_waitrequest, input, 1, and m_readdatavalid, input, 1, carrying downstream handshake signals.
REQ-012 The block SHALL have port m_readdata, input, DATA_W, carrying downstream read data.

Function
REQ-013 The block SHALL implement FSM states IDLE, CMD and RDWAIT; exactly one transaction SHALL be in flight at a time.
REQ-014 In IDLE, if any sN_read|sN_write is high, the block SHALL register the winner as owner and go to CMD next cycle; otherwise it SHALL stay in IDLE.
REQ-015 In CMD, the block SHALL drive m_* from the owner's inputs combinationally; the minimum latency from request to downstream strobe SHALL be 1 cycle.
REQ-016 sN_waitrequest SHALL be 1 for every requester except the owner in CMD while m_waitrequest=0.
REQ-017 A write accepted in CMD (m_waitrequest=0) SHALL return the FSM to IDLE; a read accepted in CMD SHALL go to RDWAIT.
REQ-018 In RDWAIT, m_readdatavalid SHALL be routed to the owner's sN_readdatavalid only, and the FSM SHALL return to IDLE.
REQ-019 m_readdata SHALL drive all sN_readdata.
REQ-020 If a requester asserts read and write together, the block SHALL treat it as a write.
REQ-021 If the owner drops both strobes in CMD, the block SHALL issue nothing and return to IDLE.
REQ-022 A new request arriving in the cycle a transaction completes SHALL be arbitrated in IDLE on the following cycle; there SHALL be no back-to-back bypass.
REQ-023 m_readdatavalid outside RDWAIT SHALL be ignored and not forwarded.

Reset
REQ-024 While rst is high, the block SHALL be in state IDLE with owner=1 and the priority pointer pointing to requester 1.
REQ-025 While rst is high, m_write=0, m_read=0, m_address=0, m_writedata=0, all sN_waitrequest=1 and all sN_readdatavalid=0.
REQ-026 Reset asserted mid-transaction SHALL abort it immediately; no return SHALL be forwarded after release.

Configuration
REQ-027 With UART_ARB_ROUND_ROBIN_EN defined, arbitration SHALL be round-robin, with the requester after the last owner having highest priority and the pointer updating on completion.
REQ-028 Without UART_ARB_ROUND_ROBIN_EN, arbitration SHALL be fixed priority s1 > s2 > s3, with no pointer register.

Structure
REQ-029 Package uart_arb_pkg SHALL hold the FSM state typedef, N_REQ=3 and the owner-index typedef.
REQ-030 Sub-module uart_arb_pick SHALL be a combinational winner selector, taking the request vector and pointer and returning the owner index.

Verification
REQ-031 Single write: s2_write=1, addr 0x0010, data 0xA5 -> m_write high 1 cycle after, m_address=0x0010, s2_waitrequest=0 in that cycle only.
REQ-032 Read with wait: s1_read, m_waitrequest=1 for 3 cycles, readdatavalid 2 cycles later with 0x1234 -> s1_readdatavalid=1 with s1_readdata=0x1234, and s2_readdatavalid and s3_readdatavalid stay 0.
REQ-033 Contention: all three continuously request writes -> grant order 1,2,3,1 (RR) or 1,1,1 (fixed).
REQ-034 Read/write collision: s3 read+write together -> m_write=1, m_read=0.
REQ-035 Reset in RDWAIT: rst pulse, then m_readdatavalid=1 -> no sN_readdatavalid asserted, FSM in IDLE.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// ---------------------------------------------------------------------------
// uart_arb_pkg
// Shared types and constants for the three-requester bus arbiter.
//   state_t  : arbiter FSM states (IDLE / CMD / RDWAIT)
//   owner_t  : requester number, 1..3 (0 is never used)
//   N_REQ    : number of upstream requesters
//   next_owner(): round-robin successor of a requester number (3 wraps to 1)
// Optional feature macro: UART_ARB_ROUND_ROBIN_EN (used by uart_bus_arbiter).
// ---------------------------------------------------------------------------
package uart_arb_pkg;

  localparam int N_REQ = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CMD    = 2'd1,
    ST_RDWAIT = 2'd2
  } state_t;

  typedef logic [1:0] owner_t;

  function automatic owner_t next_owner(input owner_t cur);
    return (cur == owner_t'(N_REQ)) ? owner_t'(1) : owner_t'(cur + owner_t'(1));
  endfunction

endpackage

// File: rtl/uart_arb_pick.sv
// ---------------------------------------------------------------------------
// uart_arb_pick
// Combinational winner selector. Scans the request vector starting at the
// requester named by ptr and wrapping around; the first active request wins.
// With ptr held at 1 this degenerates to fixed priority s1 > s2 > s3.
// Ports:
//   req    : request vector, bit 0 = requester 1
//   ptr    : requester number (1..3) with highest priority this cycle
//   winner : requester number of the selected request (ptr if none active)
// ---------------------------------------------------------------------------
module uart_arb_pick
  import uart_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  owner_t           ptr,
  output owner_t           winner
);

  always_comb begin
    int  base;
    int  idx;
    logic found;
    winner = ptr;
    found  = 1'b0;
    // ptr is never 0 in practice; treat it as requester 1 to stay in range
    base   = (ptr == owner_t'(0)) ? 0 : int'(ptr) - 1;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (base + k) % N_REQ;
      if (!found && req[idx]) begin
        winner = owner_t'(idx + 1);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_bus_arbiter.sv
// ---------------------------------------------------------------------------
// uart_bus_arbiter
// Three-requester to one-master memory-mapped bus arbiter; one transaction
// in flight at a time. IDLE registers a winner, CMD forwards the owner's
// command combinationally, RDWAIT routes the read return to the owner.
// Ports:
//   clk, rst                       : clock, asynchronous active-high reset
//   sN_write/read/address/writedata: requester N command (N = 1..3)
//   sN_waitrequest                 : stall to requester N
//   sN_readdatavalid/readdata      : read return to requester N
//   m_write/read/address/writedata : shared downstream command
//   m_waitrequest/readdatavalid/readdata : downstream handshake and data
// Build option: define UART_ARB_ROUND_ROBIN_EN for round-robin arbitration;
// otherwise fixed priority s1 > s2 > s3 with no pointer register.
// ---------------------------------------------------------------------------
module uart_bus_arbiter
  import uart_arb_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s1_write,
  input  logic              s1_read,
  input  logic [ADDR_W-1:0] s1_address,
  input  logic [DATA_W-1:0] s1_writedata,
  output logic              s1_waitrequest,
  output logic              s1_readdatavalid,
  output logic [DATA_W-1:0] s1_readdata,
  input  logic              s2_write,
  input  logic              s2_read,
  input  logic [ADDR_W-1:0] s2_address,
  input  logic [DATA_W-1:0] s2_writedata,
  output logic              s2_waitrequest,
  output logic              s2_readdatavalid,
  output logic [DATA_W-1:0] s2_readdata,
  input  logic              s3_write,
  input  logic              s3_read,
  input  logic [ADDR_W-1:0] s3_address,
  input  logic [DATA_W-1:0] s3_writedata,
  output logic              s3_waitrequest,
  output logic              s3_readdatavalid,
  output logic [DATA_W-1:0] s3_readdata,
  output logic              m_write,
  output logic              m_read,
  output logic [ADDR_W-1:0] m_address,
  output logic [DATA_W-1:0] m_writedata,
  input  logic              m_waitrequest,
  input  logic              m_readdatavalid,
  input  logic [DATA_W-1:0] m_readdata
);

  state_t           state_q, state_d;
  owner_t           owner_q, owner_d;
  owner_t           winner;
  owner_t           ptr;
  logic [N_REQ-1:0] req_vec;
  logic [N_REQ-1:0] wait_vec;
  logic [N_REQ-1:0] rdv_vec;

  logic              own_wr, own_rd;
  logic [ADDR_W-1:0] own_addr;
  logic [DATA_W-1:0] own_wdata;
  logic              xfer_done;

  assign req_vec = {s3_write | s3_read, s2_write | s2_read, s1_write | s1_read};

  uart_arb_pick u_pick (
    .req    (req_vec),
    .ptr    (ptr),
    .winner (winner)
  );

  // Owner's command fields, selected by the registered owner number
  always_comb begin
    own_wr    = s1_write;
    own_rd    = s1_read;
    own_addr  = s1_address;
    own_wdata = s1_writedata;
    case (owner_q)
      owner_t'(2): begin
        own_wr    = s2_write;
        own_rd    = s2_read;
        own_addr  = s2_address;
        own_wdata = s2_writedata;
      end
      owner_t'(3): begin
        own_wr    = s3_write;
        own_rd    = s3_read;
        own_addr  = s3_address;
        own_wdata = s3_writedata;
      end
      default: ;
    endcase
  end

  // A transaction completes when a write is accepted or read data returns
  assign xfer_done = ((state_q == ST_CMD) && own_wr && !m_waitrequest) ||
                     ((state_q == ST_RDWAIT) && m_readdatavalid);

`ifdef UART_ARB_ROUND_ROBIN_EN
  owner_t ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (xfer_done) ptr_d = next_owner(owner_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= owner_t'(1);
    else     ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
`else
  assign ptr = owner_t'(1);
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= owner_t'(1);
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    case (state_q)
      ST_IDLE: begin
        if (|req_vec) begin
          state_d = ST_CMD;
          owner_d = winner;
        end
      end
      ST_CMD: begin
        if (!own_wr && !own_rd) state_d = ST_IDLE;   // owner withdrew
        else if (!m_waitrequest) state_d = own_wr ? ST_IDLE : ST_RDWAIT;
      end
      ST_RDWAIT: begin
        if (m_readdatavalid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: write takes precedence when both strobes are high
  always_comb begin
    m_write     = 1'b0;
    m_read      = 1'b0;
    m_address   = '0;
    m_writedata = '0;
    if (state_q == ST_CMD) begin
      m_write     = own_wr;
      m_read      = own_rd & ~own_wr;
      m_address   = own_addr;
      m_writedata = own_wdata;
    end
  end

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
    assign wait_vec[gi] = ~((state_q == ST_CMD) && (owner_q == owner_t'(gi + 1)) &&
                            !m_waitrequest);
    assign rdv_vec[gi]  = (state_q == ST_RDWAIT) && (owner_q == owner_t'(gi + 1)) &&
                          m_readdatavalid;
  end

  assign s1_waitrequest   = wait_vec[0];
  assign s2_waitrequest   = wait_vec[1];
  assign s3_waitrequest   = wait_vec[2];
  assign s1_readdatavalid = rdv_vec[0];
  assign s2_readdatavalid = rdv_vec[1];
  assign s3_readdatavalid = rdv_vec[2];
  assign s1_readdata      = m_readdata;
  assign s2_readdata      = m_readdata;
  assign s3_readdata      = m_readdata;

endmodule
